// File: rtl/inv_cipher.sv
// Iterative AES-128/192/256 inverse cipher: on-chip key expansion, then one inverse round per cycle.
// Optional build macro AES_INV_KEY_CACHE_EN skips re-expansion when the key and type repeat.
module inv_cipher #(
   parameter int SIZE_RAM  = 60,
   parameter int SIZE_DATA = 128,
   parameter int SIZE_KEY  = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ready_i,
   input  logic [1:0]           type_AES,
   input  logic [SIZE_DATA-1:0] cipher_text_i,
   input  logic [SIZE_KEY-1:0]  cipher_key_i,
   output logic                 done_o,
   output logic [SIZE_DATA-1:0] plain_text_o
);
   // state    | meaning
   // IDLE     | wait for ready_i, hold outputs
   // KEY_LOAD | copy w[0..7] from the latched key
   // KEY_EXP  | expand one schedule word per cycle
   // ARK_INIT | add the last round key
   // ROUND    | inverse rounds Nr-1 .. 1
   // FINAL    | last round without InvMixColumns, raise done_o
   typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_EXP, ARK_INIT, ROUND, FINAL} state_t;

   // S-boxes are derived from the GF(2^8) inverse to avoid two 256-entry tables.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r, p, e;
      r = 8'h01; p = a; e = 8'd254;
      for (int k = 0; k < 8; k++) begin
         if (e[k]) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      logic [15:0] d;
      d = {a, a} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] t);
      return (t == 2'b01) ? 4'd12 : (t == 2'b10) ? 4'd14 : 4'd10;
   endfunction

   state_t               r_fsm, w_fsm_nxt;
   logic [127:0]         r_data;
   logic [255:0]         r_key;
   logic [1:0]           r_type;
   logic [5:0]           r_idx;
   logic [2:0]           r_mod;
   logic [7:0]           r_rcon;
   logic [3:0]           r_round;
   logic [31:0]          r_w [SIZE_RAM];
   logic [5:0]           w_nk, w_last, w_rk_base;
   logic [2:0]           w_nk_m1;
   logic [31:0]          w_prev, w_t, w_new;
   logic [127:0]         w_rk;
   logic                 w_cache_hit;

   assign w_nk    = (r_type == 2'b01) ? 6'd6  : (r_type == 2'b10) ? 6'd8  : 6'd4;
   assign w_nk_m1 = (r_type == 2'b01) ? 3'd5  : (r_type == 2'b10) ? 3'd7  : 3'd3;
   assign w_last  = (r_type == 2'b01) ? 6'd51 : (r_type == 2'b10) ? 6'd59 : 6'd43;

   // r_mod tracks i mod Nk and r_rcon tracks Rcon(i/Nk), so no divider is needed.
   assign w_prev = r_w[r_idx - 6'd1];
   always_comb begin
      w_t = w_prev;
      if (r_mod == 3'd0)
         w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
      else if (r_type == 2'b10 && r_mod == 3'd4)
         w_t = sub_word(w_prev);
   end
   assign w_new = r_w[r_idx - w_nk] ^ w_t;

   assign w_rk_base = {r_round, 2'b00};
   assign w_rk = {r_w[w_rk_base], r_w[w_rk_base + 6'd1], r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

`ifdef AES_INV_KEY_CACHE_EN
   logic         r_key_valid;
   logic [255:0] r_cache_key;
   logic [1:0]   r_cache_type;
   logic [255:0] w_key_mask;
   assign w_key_mask = (type_AES == 2'b01) ? {{192{1'b1}}, 64'h0} :
                       (type_AES == 2'b10) ? {256{1'b1}} : {{128{1'b1}}, 128'h0};
   assign w_cache_hit = r_key_valid && (type_AES == r_cache_type) &&
                        (((cipher_key_i ^ r_cache_key) & w_key_mask) == '0);
`else
   assign w_cache_hit = 1'b0;
`endif

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         IDLE:     if (ready_i) w_fsm_nxt = w_cache_hit ? ARK_INIT : KEY_LOAD;
         KEY_LOAD: w_fsm_nxt = KEY_EXP;
         KEY_EXP:  if (r_idx == w_last) w_fsm_nxt = ARK_INIT;
         ARK_INIT: w_fsm_nxt = ROUND;
         ROUND:    if (r_round == 4'd1) w_fsm_nxt = FINAL;
         FINAL:    w_fsm_nxt = IDLE;
         default:  w_fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fsm        <= IDLE;
         r_data       <= '0;
         r_key        <= '0;
         r_type       <= '0;
         r_idx        <= '0;
         r_mod        <= '0;
         r_rcon       <= '0;
         r_round      <= '0;
         done_o       <= 1'b0;
         plain_text_o <= '0;
`ifdef AES_INV_KEY_CACHE_EN
         r_key_valid  <= 1'b0;
         r_cache_key  <= '0;
         r_cache_type <= '0;
`endif
      end else begin
         r_fsm <= w_fsm_nxt;
         case (r_fsm)
            IDLE: if (ready_i) begin
               r_data  <= cipher_text_i;
               r_key   <= cipher_key_i;
               r_type  <= type_AES;
               r_round <= nr_of(type_AES);
               done_o  <= 1'b0;
            end
            KEY_LOAD: begin
               r_idx  <= w_nk;
               r_mod  <= '0;
               r_rcon <= 8'h01;
`ifdef AES_INV_KEY_CACHE_EN
               r_key_valid <= 1'b0;
`endif
            end
            KEY_EXP: begin
               r_idx <= r_idx + 6'd1;
               r_mod <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
               if (r_mod == 3'd0)
                  r_rcon <= r_rcon[7] ? ({r_rcon[6:0], 1'b0} ^ 8'h1b) : {r_rcon[6:0], 1'b0};
`ifdef AES_INV_KEY_CACHE_EN
               if (r_idx == w_last) begin
                  r_key_valid  <= 1'b1;
                  r_cache_key  <= r_key;
                  r_cache_type <= r_type;
               end
`endif
            end
            ARK_INIT: begin
               r_data  <= r_data ^ w_rk;
               r_round <= r_round - 4'd1;
            end
            ROUND: begin
               r_data  <= inv_mix(inv_sr_sb(r_data) ^ w_rk);
               r_round <= r_round - 4'd1;
            end
            FINAL: begin
               plain_text_o <= inv_sr_sb(r_data) ^ w_rk;
               done_o       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Key schedule storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (r_fsm == KEY_LOAD) begin
         for (int k = 0; k < 8; k++) r_w[k] <= r_key[255-32*k -: 32];
      end else if (r_fsm == KEY_EXP) begin
         r_w[r_idx] <= w_new;
      end
   end
endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher: FIPS-197 vectors, handshake, mid-run reset, optional key cache.
module tb_inv_cipher;
   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         ready_i = 1'b0;
   logic [1:0]   type_AES = '0;
   logic [127:0] cipher_text_i = '0;
   logic [255:0] cipher_key_i = '0;
   logic         done_o;
   logic [127:0] plain_text_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

   typedef struct {
      logic [1:0]   t;
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           lat;
   } vec_t;

   vec_t tbl[4];

   always #5 clk_i = ~clk_i;

   inv_cipher #(.SIZE_RAM(60), .SIZE_DATA(128), .SIZE_KEY(256)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ready_i(ready_i), .type_AES(type_AES),
      .cipher_text_i(cipher_text_i), .cipher_key_i(cipher_key_i),
      .done_o(done_o), .plain_text_o(plain_text_o));

   task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start(input vec_t v, input bit hold);
      @(negedge clk_i);
      type_AES = v.t; cipher_key_i = v.key; cipher_text_i = v.ct; ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      if (!hold) ready_i = 1'b0;
      cipher_text_i = ~cipher_text_i;
      cipher_key_i  = ~cipher_key_i;
   endtask

   // Counts edges after the accept edge until done_o is seen; optional one-cycle ready pulse.
   task automatic wait_done(input int pulse_at, output int cyc);
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 200) begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (pulse_at > 0) ready_i = (cyc == pulse_at);
      end
   endtask

   task automatic run(input string name, input vec_t v, input int lat, input bit chk_pt);
      int cyc;
      start(v, 1'b0);
      wait_done(-1, cyc);
      check_int({name, " latency"}, cyc, lat);
      if (chk_pt) check_val({name, " pt"}, plain_text_o, v.pt);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check_val("reset done", {127'h0, done_o}, 128'h0);
      check_val("reset pt", plain_text_o, 128'h0);
      rst_ni = 1'b1;
   endtask

   task automatic reset_mid(input string name, input int edges);
      start(tbl[0], 1'b0);
      repeat (edges) @(posedge clk_i);
      #1 rst_ni = 1'b0;
      @(negedge clk_i);
      check_val({name, " done"}, {127'h0, done_o}, 128'h0);
      check_val({name, " pt"}, plain_text_o, 128'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run({name, " rerun"}, tbl[0], 52, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      vec_t v;
      tbl[0] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 52};
      tbl[1] = '{2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 60};
      tbl[2] = '{2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                 128'h8ea2b7ca516745bfeafc49904b496089, PT, 68};
      tbl[3] = '{2'b11, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 52};

      do_reset();
      repeat (5) @(negedge clk_i);
      check_val("idle done", {127'h0, done_o}, 128'h0);
      check_val("idle pt", plain_text_o, 128'h0);

      for (int k = 0; k < 4; k++) begin
         run($sformatf("vec%0d", k), tbl[k], tbl[k].lat, 1'b1);
         check_val($sformatf("vec%0d done", k), {127'h0, done_o}, 128'h1);
      end

      start(tbl[0], 1'b0);
      wait_done(20, cyc);
      check_int("pulse latency", cyc, 52);
      check_val("pulse pt", plain_text_o, PT);

      start(tbl[1], 1'b1);
      type_AES = tbl[2].t; cipher_key_i = tbl[2].key; cipher_text_i = tbl[2].ct;
      wait_done(-1, cyc);
      check_int("hold first latency", cyc, 60);
      check_val("hold first pt", plain_text_o, PT);
      @(posedge clk_i);
      #1;
      check_val("hold accept done", {127'h0, done_o}, 128'h0);
      check_val("hold accept pt kept", plain_text_o, PT);
      ready_i = 1'b0;
      wait_done(-1, cyc);
      check_int("hold second latency", cyc, 68);
      check_val("hold second pt", plain_text_o, PT);

      reset_mid("rst keyexp", 10);
      reset_mid("rst round", 45);

`ifdef AES_INV_KEY_CACHE_EN
      run("cache hit", tbl[0], 11, 1'b1);
      v = tbl[0];
      v.key[250] = ~v.key[250];
      run("cache key change", v, 52, 1'b0);
      run("cache restore", tbl[0], 52, 1'b1);
      v = tbl[0];
      v.key[3] = ~v.key[3];
      run("cache unused bits", v, 11, 1'b1);
      do_reset();
      run("cache after reset", tbl[0], 52, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
